// File: rtl/mac_dot_if.sv
// mac_dot_if: operand stream and result handshake bundle for mac_dot.
interface mac_dot_if #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 26
);
  logic                    in_vld;
  logic                    in_rdy;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic                    out_vld;
  logic                    out_rdy;
  logic signed [ACC_W-1:0] acc_out;
  logic                    ovf;
  modport master (output in_vld, a, b, out_rdy, input in_rdy, out_vld, acc_out, ovf);
  modport slave  (input in_vld, a, b, out_rdy, output in_rdy, out_vld, acc_out, ovf);
endinterface

// File: rtl/mac_dot.sv
// mac_dot: streaming signed dot-product MAC, multiply then accumulate stages, held result register.
// Define SATURATE_EN for clamping adds with a sticky per-vector ovf flag; otherwise adds wrap.
module mac_dot #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 26,
  parameter int LEN   = 16
) (
  input logic      clk,
  input logic      rst,
  input logic      clr,
  mac_dot_if.slave io
);
  localparam int P_W = A_W + B_W;
  localparam int C_W = LEN > 1 ? $clog2(LEN) : 1;
  if (ACC_W < A_W + B_W) begin : g_acc_w_chk
    $error("mac_dot: ACC_W must be at least A_W+B_W");
  end
  logic [C_W-1:0]          cnt_q, cnt_d;
  logic signed [P_W-1:0]   p_q, p_d;
  logic                    p_vld_q, p_vld_d, p_last_q, p_last_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_out_q, acc_out_d, sum;
  logic                    out_vld_q, out_vld_d;
  logic                    stall, take, add;
  assign stall     = out_vld_q && !io.out_rdy;
  assign io.in_rdy = !rst && !clr && !stall;
  assign take      = io.in_vld && io.in_rdy;
  assign add       = p_vld_q && !stall && !clr;
`ifdef SATURATE_EN
  logic signed [ACC_W:0] wide;
  logic                  clamp, sat_q, sat_d, ovf_q, ovf_d;
  always_comb begin
    wide  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(p_q);
    clamp = wide[ACC_W] != wide[ACC_W-1];
    sum   = clamp ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
    sat_d = clr ? 1'b0 : add ? !p_last_q && (sat_q || clamp) : sat_q;
    ovf_d = add && p_last_q ? sat_q || clamp : ovf_q;
  end
  always_ff @(posedge clk) begin
    sat_q <= rst ? 1'b0 : sat_d;
    ovf_q <= rst ? 1'b0 : ovf_d;
  end
  assign io.ovf = ovf_q;
`else
  assign sum    = acc_q + ACC_W'(p_q);
  assign io.ovf = 1'b0;
`endif
  always_comb begin
    cnt_d     = cnt_q;
    p_d       = p_q;
    p_vld_d   = p_vld_q;
    p_last_d  = p_last_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    out_vld_d = stall;
    if (clr) begin
      cnt_d   = '0;
      p_vld_d = 1'b0;
      acc_d   = '0;
    end else if (!stall) begin
      p_vld_d = take;
      if (take) begin
        p_d      = P_W'(io.a) * P_W'(io.b);
        p_last_d = cnt_q == C_W'(LEN - 1);
        cnt_d    = p_last_d ? '0 : cnt_q + C_W'(1);
      end
    end
    // the final product of a vector bypasses acc straight into the held result
    if (add) begin
      acc_d = p_last_q ? '0 : sum;
      if (p_last_q) begin
        acc_out_d = sum;
        out_vld_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      p_q       <= '0;
      p_vld_q   <= 1'b0;
      p_last_q  <= 1'b0;
      acc_q     <= '0;
      acc_out_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      p_vld_q   <= p_vld_d;
      p_last_q  <= p_last_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      out_vld_q <= out_vld_d;
    end
  end
  assign io.out_vld = out_vld_q;
  assign io.acc_out = acc_out_q;
endmodule
